// File: rtl/int_priority_ctrl.sv
// Interrupt front-end for the multicycle MIPS Controller: N maskable level IRQs plus an edge NMI,
// with a request/ack handshake and one level of NMI nesting. Define ROUND_ROBIN_EN for rotating IRQ priority.
module int_priority_ctrl #(
    parameter int              N_IRQ    = 8,
    parameter int              ID_W     = 3,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] VEC_BASE = 32'h0000_0180,
    parameter logic [PC_W-1:0] NMI_VEC  = 32'h0000_0100
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [N_IRQ-1:0] IRQ,
    input  logic [N_IRQ-1:0] Mask,
    input  logic             NMI,
    input  logic             IntEn,
    input  logic             IntAck,
    input  logic             Eret,
    output logic             IntReq,
    output logic             NmiSel,
    output logic [ID_W-1:0]  IntId,
    output logic [PC_W-1:0]  VecAddr,
    output logic             InService,
    output logic [N_IRQ-1:0] Pending
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SVC, ST_NMI_SVC} state_t;

    state_t            state_q, state_d;
    logic              nmi_sel_q, nmi_sel_d;
    logic [ID_W-1:0]   int_id_q, int_id_d;
    logic [PC_W-1:0]   vec_addr_q, vec_addr_d;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic              nmi_pend_q, nmi_pend_d;
    logic              nmi_prev_q, nmi_prev_d;
    logic              nested_q, nested_d;
    logic [ID_W-1:0]   saved_id_q, saved_id_d;

    logic [ID_W-1:0]   lo_id;
    logic [ID_W-1:0]   sel_id;

    function automatic logic [PC_W-1:0] vec_of(input logic [ID_W-1:0] id);
        logic [PC_W-1:0] off;
        off = '0;
        off[ID_W+2:3] = id;
        return VEC_BASE + off;
    endfunction

`ifdef ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            hi_found;
    logic [ID_W-1:0] hi_id;
`endif

    // Lowest pending index; with rotation, prefer the lowest index above the last grant.
    always_comb begin
        lo_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) lo_id = ID_W'(i);
        end
`ifdef ROUND_ROBIN_EN
        hi_found = 1'b0;
        hi_id    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i] && (ID_W'(i) > rr_ptr_q)) begin
                hi_found = 1'b1;
                hi_id    = ID_W'(i);
            end
        end
        sel_id   = hi_found ? hi_id : lo_id;
        rr_ptr_d = (state_q == ST_REQ && IntAck && !nmi_sel_q) ? int_id_q : rr_ptr_q;
`else
        sel_id = lo_id;
`endif
    end

    always_comb begin
        state_d    = state_q;
        nmi_sel_d  = nmi_sel_q;
        int_id_d   = int_id_q;
        vec_addr_d = vec_addr_q;
        nested_d   = nested_q;
        saved_id_d = saved_id_q;
        nmi_pend_d = nmi_pend_q;
        pending_d  = IRQ & ~Mask;
        nmi_prev_d = NMI;

        case (state_q)
            ST_IDLE: begin
                if (nmi_pend_q) begin
                    state_d    = ST_REQ;
                    nmi_sel_d  = 1'b1;
                    vec_addr_d = NMI_VEC;
                end else if (IntEn && (|pending_q)) begin
                    state_d    = ST_REQ;
                    nmi_sel_d  = 1'b0;
                    int_id_d   = sel_id;
                    vec_addr_d = vec_of(sel_id);
                end
            end
            ST_REQ: begin
                // Acknowledge beats upgrade/withdraw: the registered request is what the Controller took.
                if (IntAck) begin
                    if (nmi_sel_q) begin
                        state_d    = ST_NMI_SVC;
                        nmi_pend_d = 1'b0;
                    end else begin
                        state_d = ST_SVC;
                    end
                end else if (!nmi_sel_q && nmi_pend_q) begin
                    nmi_sel_d  = 1'b1;
                    vec_addr_d = NMI_VEC;
                end else if (!nmi_sel_q && (!pending_q[int_id_q] || !IntEn)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (nmi_pend_q) begin
                    state_d    = ST_REQ;
                    nested_d   = 1'b1;
                    saved_id_d = int_id_q;
                    nmi_sel_d  = 1'b1;
                    vec_addr_d = NMI_VEC;
                end else if (Eret) begin
                    state_d = ST_IDLE;
                end
            end
            ST_NMI_SVC: begin
                if (Eret) begin
                    nmi_sel_d = 1'b0;
                    if (nested_q) begin
                        state_d    = ST_SVC;
                        nested_d   = 1'b0;
                        int_id_d   = saved_id_q;
                        vec_addr_d = vec_of(saved_id_q);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new edge is recorded even on the cycle an earlier NMI is acknowledged.
        if (NMI && !nmi_prev_q) nmi_pend_d = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            nmi_sel_q  <= 1'b0;
            int_id_q   <= '0;
            vec_addr_q <= VEC_BASE;
            pending_q  <= '0;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= 1'b1;
            nested_q   <= 1'b0;
            saved_id_q <= '0;
        end else begin
            state_q    <= state_d;
            nmi_sel_q  <= nmi_sel_d;
            int_id_q   <= int_id_d;
            vec_addr_q <= vec_addr_d;
            pending_q  <= pending_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_prev_q <= nmi_prev_d;
            nested_q   <= nested_d;
            saved_id_q <= saved_id_d;
        end
    end

`ifdef ROUND_ROBIN_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) rr_ptr_q <= ID_W'(N_IRQ - 1);
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    // The interrupted IRQ handler stays in service while its nested NMI is being requested.
    assign IntReq    = (state_q == ST_REQ);
    assign InService = (state_q == ST_SVC) || (state_q == ST_NMI_SVC) || nested_q;
    assign NmiSel    = nmi_sel_q;
    assign IntId     = int_id_q;
    assign VecAddr   = vec_addr_q;
    assign Pending   = pending_q;

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Bench for int_priority_ctrl: vector table, hand-written corner sequences, and random stimulus
// checked against a request/handler-stack reference model.
module tb_int_priority_ctrl;
    localparam int          N  = 8;
    localparam logic [31:0] VB = 32'h0000_0180;
    localparam logic [31:0] NV = 32'h0000_0100;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [7:0]  IRQ, Mask;
    logic        NMI, IntEn, IntAck, Eret;
    logic        IntReq, NmiSel, InService;
    logic [2:0]  IntId;
    logic [31:0] VecAddr;
    logic [7:0]  Pending;

    int checks = 0;
    int errors = 0;

    int_priority_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .IRQ(IRQ), .Mask(Mask), .NMI(NMI), .IntEn(IntEn),
        .IntAck(IntAck), .Eret(Eret), .IntReq(IntReq), .NmiSel(NmiSel), .IntId(IntId),
        .VecAddr(VecAddr), .InService(InService), .Pending(Pending)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  irq, mask;
        logic        nmi, inten, ack, eret;
        logic        exp_req, exp_nmi;
        logic [2:0]  exp_id;
        logic [31:0] exp_vec;
        logic        exp_svc;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic [7:0] irq, logic [7:0] mask, logic nmi, logic inten,
                                logic ack, logic eret, logic req, logic nsel, logic [2:0] id,
                                logic [31:0] vec, logic svc);
        vec_t v;
        v.irq = irq; v.mask = mask; v.nmi = nmi; v.inten = inten; v.ack = ack; v.eret = eret;
        v.exp_req = req; v.exp_nmi = nsel; v.exp_id = id; v.exp_vec = vec; v.exp_svc = svc;
        return v;
    endfunction

    function automatic logic [63:0] pack(logic req, logic nsel, logic [2:0] id, logic [31:0] vec,
                                         logic svc, logic [7:0] pend);
        return {18'b0, req, nsel, id, vec, svc, pend};
    endfunction

    function automatic logic [63:0] dut_bus();
        return pack(IntReq, NmiSel, IntId, VecAddr, InService, Pending);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(logic [7:0] irq, logic [7:0] mask, logic nmi, logic inten, logic ack, logic eret);
        IRQ = irq; Mask = mask; NMI = nmi; IntEn = inten; IntAck = ack; Eret = eret;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        step();
        step();
        Rst_n = 1'b1;
    endtask

    // ---------------- reference model: one outstanding request plus a stack of active handlers
    typedef struct { bit nmi; int id; } hrec_t;
    hrec_t       m_stack[$];
    bit [7:0]    m_pend;
    bit          m_prev, m_nmi, m_req, m_req_nmi;
    int          m_req_id, m_id, m_last;
    logic [31:0] m_vec;

    task automatic model_reset();
        m_stack.delete();
        m_pend = '0; m_prev = 1'b1; m_nmi = 1'b0;
        m_req = 1'b0; m_req_nmi = 1'b0; m_req_id = 0;
        m_id = 0; m_vec = VB; m_last = N - 1;
    endtask

    function automatic int pick(bit [7:0] p, int last);
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (p[idx[2:0]]) return idx;
        end
`else
        for (int i = 0; i < N; i++) if (p[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_step(bit [7:0] irq, bit [7:0] mask, bit nmi, bit inten, bit ack, bit eret);
        bit [7:0] old_pend;
        bit       nmi_edge;
        int       k;
        old_pend = m_pend;
        nmi_edge = nmi && !m_prev;
        if (m_req) begin
            if (ack) begin
                m_stack.push_back('{nmi: m_req_nmi, id: m_req_id});
                m_req = 1'b0;
                if (m_req_nmi) m_nmi = 1'b0;
                else           m_last = m_req_id;
            end else if (!m_req_nmi && m_nmi) begin
                m_req_nmi = 1'b1;
                m_vec = NV;
            end else if (!m_req_nmi && (!old_pend[m_req_id[2:0]] || !inten)) begin
                m_req = 1'b0;
            end
        end else if (m_stack.size() == 0) begin
            if (m_nmi) begin
                m_req = 1'b1; m_req_nmi = 1'b1; m_vec = NV;
            end else if (inten && old_pend != 0) begin
                k = pick(old_pend, m_last);
                m_req = 1'b1; m_req_nmi = 1'b0; m_req_id = k; m_id = k;
                m_vec = VB + 32'(k * 8);
            end
        end else if (!m_stack[$].nmi) begin
            if (m_nmi) begin
                m_req = 1'b1; m_req_nmi = 1'b1; m_vec = NV;
            end else if (eret) begin
                void'(m_stack.pop_back());
            end
        end else if (eret) begin
            void'(m_stack.pop_back());
            if (m_stack.size() > 0) begin
                m_id  = m_stack[$].id;
                m_vec = VB + 32'(m_id * 8);
            end
        end
        if (nmi_edge) m_nmi = 1'b1;
        m_prev = nmi;
        m_pend = irq & ~mask;
    endtask

    function automatic logic [63:0] model_bus();
        logic nsel;
        nsel = m_req ? m_req_nmi : (m_stack.size() > 0 && m_stack[$].nmi);
        return pack(m_req, nsel, m_id[2:0], m_vec, m_stack.size() > 0, m_pend);
    endfunction

    initial begin
        int          rr_exp[3];
        int          waited;
        logic [7:0]  r_irq, r_mask;
        logic        r_nmi, r_en, r_ack, r_eret;
        logic        pre_req, pre_nmi;
        logic [2:0]  pre_id;

        tbl[0]  = mk(8'h28, 8'h00, 0, 1, 0, 0, 0, 0, 3'd0, 32'h180, 0);
        tbl[1]  = mk(8'h28, 8'h00, 0, 1, 0, 0, 1, 0, 3'd3, 32'h198, 0);
        tbl[2]  = mk(8'h28, 8'h00, 0, 1, 1, 0, 0, 0, 3'd3, 32'h198, 1);
        tbl[3]  = mk(8'h00, 8'h00, 0, 1, 0, 1, 0, 0, 3'd3, 32'h198, 0);
        tbl[4]  = mk(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 3'd3, 32'h198, 0);
        tbl[5]  = mk(8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 3'd3, 32'h198, 0);
        tbl[6]  = mk(8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 3'd3, 32'h198, 0);
        tbl[7]  = mk(8'h01, 8'h00, 0, 1, 0, 0, 1, 0, 3'd0, 32'h180, 0);
        tbl[8]  = mk(8'h01, 8'h00, 0, 1, 1, 0, 0, 0, 3'd0, 32'h180, 1);
        tbl[9]  = mk(8'h01, 8'h00, 1, 1, 0, 0, 0, 0, 3'd0, 32'h180, 1);
        tbl[10] = mk(8'h01, 8'h00, 0, 1, 0, 0, 1, 1, 3'd0, 32'h100, 1);
        tbl[11] = mk(8'h01, 8'h00, 0, 1, 1, 0, 0, 1, 3'd0, 32'h100, 1);
        tbl[12] = mk(8'h01, 8'h00, 0, 1, 0, 1, 0, 0, 3'd0, 32'h180, 1);
        tbl[13] = mk(8'h01, 8'h00, 0, 1, 0, 0, 0, 0, 3'd0, 32'h180, 1);
        tbl[14] = mk(8'h00, 8'h00, 0, 1, 0, 1, 0, 0, 3'd0, 32'h180, 0);
        tbl[15] = mk(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 3'd0, 32'h180, 0);
        tbl[16] = mk(8'h20, 8'h00, 1, 1, 0, 0, 0, 0, 3'd0, 32'h180, 0);
        tbl[17] = mk(8'h20, 8'h00, 0, 1, 0, 0, 1, 1, 3'd0, 32'h100, 0);
        tbl[18] = mk(8'h20, 8'h00, 0, 1, 1, 0, 0, 1, 3'd0, 32'h100, 1);
        tbl[19] = mk(8'h20, 8'h00, 0, 1, 0, 1, 0, 0, 3'd0, 32'h100, 0);
        tbl[20] = mk(8'h20, 8'h00, 0, 1, 0, 0, 1, 0, 3'd5, 32'h1A8, 0);
        tbl[21] = mk(8'h20, 8'h00, 0, 1, 1, 0, 0, 0, 3'd5, 32'h1A8, 1);
        tbl[22] = mk(8'h00, 8'h00, 0, 1, 0, 1, 0, 0, 3'd5, 32'h1A8, 0);
        tbl[23] = mk(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 3'd5, 32'h1A8, 0);

        // ---------------- reset values
        Rst_n = 1'b0;
        drive(8'h00, 8'h00, 0, 0, 0, 0);
        step();
        chk("reset_state", dut_bus(), pack(0, 0, 3'd0, VB, 0, 8'h00));
        step();
        Rst_n = 1'b1;

        // ---------------- vector table
        for (int r = 0; r < 24; r++) begin
            drive(tbl[r].irq, tbl[r].mask, tbl[r].nmi, tbl[r].inten, tbl[r].ack, tbl[r].eret);
            step();
            $display("row %0d irq=%h nmi=%0b ack=%0b eret=%0b -> req=%0b nmisel=%0b id=%0d vec=%h insvc=%0b",
                     r, tbl[r].irq, tbl[r].nmi, tbl[r].ack, tbl[r].eret, IntReq, NmiSel, IntId, VecAddr, InService);
            chk($sformatf("table_row_%0d", r), dut_bus(),
                pack(tbl[r].exp_req, tbl[r].exp_nmi, tbl[r].exp_id, tbl[r].exp_vec, tbl[r].exp_svc,
                     tbl[r].irq & ~tbl[r].mask));
        end

        // ---------------- IRQ withdrawn by Mask, then Mask with simultaneous IntAck
        drive(8'h04, 8'h00, 0, 1, 0, 0);
        step(); step();
        chk("wd_req", dut_bus(), pack(1, 0, 3'd2, 32'h190, 0, 8'h04));
        drive(8'h04, 8'h04, 0, 1, 0, 0);
        step();
        chk("wd_hold", {63'b0, IntReq}, 64'd1);
        step();
        chk("wd_drop", dut_bus(), pack(0, 0, 3'd2, 32'h190, 0, 8'h00));
        step();
        chk("wd_idle", {63'b0, IntReq}, 64'd0);
        $display("withdraw: req=%0b insvc=%0b", IntReq, InService);
        drive(8'h04, 8'h00, 0, 1, 0, 0);
        step(); step();
        chk("wd2_req", dut_bus(), pack(1, 0, 3'd2, 32'h190, 0, 8'h04));
        drive(8'h04, 8'h04, 0, 1, 0, 0);
        step();
        drive(8'h04, 8'h04, 0, 1, 1, 0);
        step();
        chk("wd2_ack_wins", dut_bus(), pack(0, 0, 3'd2, 32'h190, 1, 8'h00));
        $display("ack vs withdraw: req=%0b id=%0d insvc=%0b", IntReq, IntId, InService);
        drive(8'h00, 8'h00, 0, 1, 0, 1);
        step();
        chk("wd2_eret", dut_bus(), pack(0, 0, 3'd2, 32'h190, 0, 8'h00));
        drive(8'h00, 8'h00, 0, 1, 0, 0);
        step();

        // ---------------- asynchronous reset during NMI service, NMI held across release
        drive(8'h00, 8'h00, 1, 1, 0, 0);
        step();
        drive(8'h00, 8'h00, 0, 1, 0, 0);
        step();
        chk("nmi_req", dut_bus(), pack(1, 1, 3'd2, NV, 0, 8'h00));
        drive(8'h00, 8'h00, 1, 1, 1, 0);
        step();
        chk("nmi_svc", dut_bus(), pack(0, 1, 3'd2, NV, 1, 8'h00));
        drive(8'h00, 8'h00, 1, 1, 0, 0);
        Rst_n = 1'b0;
        #1;
        chk("async_reset", dut_bus(), pack(0, 0, 3'd0, VB, 0, 8'h00));
        $display("async reset: req=%0b nmisel=%0b vec=%h insvc=%0b", IntReq, NmiSel, VecAddr, InService);
        step(); step();
        Rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("nmi_held_%0d", c), {62'b0, IntReq, NmiSel}, 64'd0);
        end
        drive(8'h00, 8'h00, 0, 1, 0, 0);
        step();

        // ---------------- selection order over three rounds with IRQ 1 and 3 held
`ifdef ROUND_ROBIN_EN
        rr_exp = '{1, 3, 1};
`else
        rr_exp = '{1, 1, 1};
`endif
        do_reset();
        drive(8'h0A, 8'h00, 0, 1, 0, 0);
        for (int r = 0; r < 3; r++) begin
            waited = 0;
            while (!IntReq && waited < 10) begin
                step();
                waited++;
            end
            if (!IntReq) begin
                checks++;
                errors++;
                $display("FAIL order_round_%0d: no IntReq within 10 cycles, required IntId %0d", r, rr_exp[r]);
            end else begin
                chk($sformatf("order_round_%0d", r), {61'b0, IntId}, 64'(rr_exp[r]));
                $display("round %0d: granted IntId=%0d", r, IntId);
            end
            IntAck = 1'b1;
            step();
            IntAck = 1'b0;
            Eret = 1'b1;
            step();
            Eret = 1'b0;
        end

        // ---------------- randomized run against the reference model
        drive(8'h00, 8'h00, 0, 0, 0, 0);
        do_reset();
        model_reset();
        r_irq = 8'h00; r_mask = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0)  r_irq  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) r_mask = 8'($urandom) & 8'($urandom);
            r_nmi  = ($urandom_range(0, 24) == 0);
            r_en   = ($urandom_range(0, 9) != 0);
            r_ack  = ($urandom_range(0, 2) == 0);
            r_eret = ($urandom_range(0, 5) == 0);
            drive(r_irq, r_mask, r_nmi, r_en, r_ack, r_eret);
            pre_req = IntReq; pre_nmi = NmiSel; pre_id = IntId;
            step();
            model_step(r_irq, r_mask, r_nmi, r_en, r_ack, r_eret);
            if (pre_req && r_ack)
                $display("rand cycle %0d: ack nmi=%0b id=%0d", c, pre_nmi, pre_id);
            chk($sformatf("rand_cycle_%0d", c), dut_bus(), model_bus());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_priority_ctrl.md
Name: int_priority_ctrl

Overview:
Parametrised interrupt front-end for the multicycle MIPS Controller.
- Replaces the single INT/NMI/INT_FLAG trio with N maskable level-sensitive IRQ lines plus one edge-triggered NMI.
- Prioritises and latches requests, then runs a request/acknowledge handshake with the Controller FSM.
- Supplies the vector ID and handler address, and tracks in-service state, including NMI nesting over an IRQ handler.

Parameters:
N_IRQ, 8, number of maskable interrupt lines (2..32)
ID_W, 3, width of IntId; must satisfy 2**ID_W >= N_IRQ
PC_W, 32, vector address width
VEC_BASE, 32'h0000_0180, IRQ vector base; handler address = VEC_BASE + (IntId << 3)
NMI_VEC, 32'h0000_0100, NMI handler address

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
IRQ  in  N_IRQ  level interrupt requests, active high
Mask  in  N_IRQ  1 = line masked
NMI  in  1  non-maskable request, rising-edge triggered
IntEn  in  1  global IRQ enable (replaces INT_FLAG); does not affect NMI
IntAck  in  1  Controller accepts the current request (one-cycle pulse)
Eret  in  1  Controller finished the handler (one-cycle pulse)
IntReq  out  1  request to Controller
NmiSel  out  1  current request or service is NMI
IntId  out  ID_W  granted IRQ index
VecAddr  out  PC_W  handler address for PCSrc mux
InService  out  1  a handler is active
Pending  out  N_IRQ  registered IRQ & ~Mask

Behaviour:
- Reset values (async, Rst_n=0): state IDLE, IntReq=0, NmiSel=0, IntId=0, VecAddr=VEC_BASE, InService=0, Pending=0, nmi_pend=0, nested=0, nmi_prev=1. Because nmi_prev resets to 1, NMI held high through reset release is not an edge.
- Pending <= IRQ & ~Mask every cycle.
- NMI edge (NMI & ~nmi_prev) sets nmi_pend. nmi_pend clears only when an NMI request is acknowledged. Further edges while nmi_pend=1 are merged.
- Latency: an IRQ or NMI edge sampled at edge k gives IntReq=1 after edge k+1.
- States are IDLE, REQ, SVC, NMI_SVC.
- IDLE:
  - If nmi_pend: go to REQ with NmiSel=1 and VecAddr=NMI_VEC.
  - Else if IntEn and |Pending: go to REQ with IntId = lowest set index of Pending and VecAddr = VEC_BASE + IntId*8.
- REQ:
  - IntReq=1. IntId and VecAddr are held stable unless upgraded to NMI.
  - IntAck: IntReq=0 next cycle. NMI request goes to NMI_SVC and clears nmi_pend; IRQ request goes to SVC.
  - IRQ request with nmi_pend set and no IntAck this cycle: upgrade to NMI (NmiSel=1, VecAddr=NMI_VEC), stay in REQ.
  - IRQ request withdrawn (Pending[IntId]=0 or IntEn=0) with no IntAck: return to IDLE with IntReq=0.
  - IntAck in the same cycle as an upgrade or withdraw condition: IntAck wins, using the current registered request.
- SVC:
  - InService=1. New IRQs are not requested.
  - nmi_pend set: nested=1, go to REQ (NMI).
  - Eret: go to IDLE, InService=0.
- NMI_SVC:
  - InService=1, NmiSel=1. Everything is blocked; further NMI edges only set nmi_pend.
  - Eret with nested=1: go to SVC, clear nested, restore IntId and VecAddr of the interrupted IRQ (saved at the nesting point).
  - Eret with nested=0: go to IDLE.
  - A pending NMI is re-requested from the next state.
- IntAck outside REQ is ignored. Eret outside SVC or NMI_SVC is ignored.
- Nesting depth is at most one: NMI over IRQ. There is no NMI over NMI.
- Changing Mask or IntEn during SVC does not terminate service.

Optional Feature:
Macro ROUND_ROBIN_EN.
- Defined: IRQ selection searches upward, circularly, from (last granted IntId + 1) mod N_IRQ. The last-grant pointer resets to N_IRQ-1, so the first search starts at index 0. The pointer updates on IntAck of an IRQ only.
- Undefined: fixed priority, lowest index wins.
- NMI behaviour is identical in both builds.

Test Plan:
- Reset release, then IRQ=8'h28, Mask=0, IntEn=1 → IntReq=1 two edges later, IntId=3, VecAddr=0x198. IntAck → SVC, InService=1. Eret → IDLE, InService=0.
- IRQ=8'h01, IntEn=0 → IntReq stays 0, Pending=8'h01. Set IntEn=1 → request for IntId=0. NMI pulse during SVC for IRQ 0 → IntReq(NMI) with VecAddr=0x100. IntAck and first Eret → back to SVC with IntId=0, VecAddr=0x180. Second Eret → IDLE.
- NMI and IRQ[5] rise in the same cycle → NMI requested first. After its Eret, IRQ 5 is requested (VecAddr=0x1A8).
- IRQ[2] in REQ, then Mask[2]=1 with no IntAck → IntReq drops, state IDLE. Repeat with IntAck in the same cycle → SVC with IntId=2.
- ROUND_ROBIN_EN, IRQ=8'h0A held, 3 ack/eret rounds → IntId sequence 1,3,1. Without the macro → 1,1,1.
- Rst_n pulled low during NMI_SVC → all outputs return to reset values immediately. NMI held high across reset release → no request.
